pwm_fade_sequencer: RTL and testbench

- Sits between spi_peripheral and pwm_peripheral, and drives pwm_duty_cycle in place of the raw SPI register.
- Ramps the applied duty cycle toward an SPI-programmed target: a fixed step every N PWM periods.
- Optional "breathe" mode oscillates between 0 and the target.
- Gives glitch-free LED fades without firmware polling.

---
 rtl/pwm_seq_pkg.sv | 29 ++
 rtl/pwm_tick_prescaler.sv | 50 +++++
 rtl/pwm_fade_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_seq_pkg
//  Description : Shared types and constants for the PWM fade sequencer.
//                Holds the sequencer state encoding, the mode encodings and
//                the default field widths used by the sequencer modules.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

    // Default field widths
    localparam int c_DUTY_W  = 8;   // matches the pwm_peripheral duty register
    localparam int c_STEP_W  = 4;   // step-size field
    localparam int c_PRESC_W = 8;   // period prescaler

    // Mode encodings for cfg_mode
    localparam logic MODE_RAMP    = 1'b0;   // ramp to target, then hold
    localparam logic MODE_BREATHE = 1'b1;   // oscillate between 0 and target

    // Sequencer state, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

endpackage : pwm_seq_pkg
`default_nettype wire

// File: rtl/pwm_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_tick_prescaler
//  Description : Divides PWM period ticks by (prescale + 1). Counts ticks and
//                raises step_en on the tick where the count equals prescale,
//                then restarts from zero.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                tick         - one-cycle pulse per PWM period
//                clear        - synchronous counter clear, overrides tick
//                prescale     - periods per step, minus 1
//                step_en      - one-cycle pulse: take a step now
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_tick_prescaler
    import pwm_seq_pkg::*;
#(
    parameter int PRESC_W = c_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale,
    output logic               step_en
);

    logic [PRESC_W-1:0] r_count;
    logic               w_match;

    assign w_match = (r_count == prescale);

    // A clear in the same cycle as a tick discards the tick entirely.
    assign step_en = tick & ~clear & w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick) begin
            if (w_match) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : pwm_tick_prescaler
`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fade_sequencer
//  Description : Ramps the applied PWM duty cycle toward a programmed target
//                by a fixed step every (prescale + 1) PWM periods. Breathe
//                mode oscillates between 0 and the target. duty_out is
//                registered and only changes on period ticks, so the PWM
//                peripheral always picks up a new duty at a period start.
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                cfg_valid      - pulse: latch cfg_target/step/prescale/mode
//                cfg_enable     - level enable; low forces IDLE
//                cfg_mode       - 0 ramp-to-target, 1 breathe
//                cfg_target     - target duty
//                cfg_step       - duty increment per step (0 acts as 1)
//                cfg_prescale   - PWM periods per step, minus 1
//                period_tick    - pulse at each PWM counter wrap
//                duty_out       - applied duty cycle
//                busy           - high while ramping
//                done           - one-cycle pulse on arrival
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W  = c_DUTY_W,
    parameter int STEP_W  = c_STEP_W,
    parameter int PRESC_W = c_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic               cfg_enable,
    input  logic               cfg_mode,
    input  logic [DUTY_W-1:0]  cfg_target,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic               period_tick,
    output logic [DUTY_W-1:0]  duty_out,
    output logic               busy,
    output logic               done
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [DUTY_W-1:0]  r_duty;
    logic               r_done;
    logic [DUTY_W-1:0]  r_target;
    logic [STEP_W-1:0]  r_step;
    logic [PRESC_W-1:0] r_prescale;
    logic               r_mode;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [DUTY_W-1:0]  w_duty_nxt;
    logic               w_done_ev;
    logic               w_done_nxt;
    logic               w_ramping;
    logic               w_step_en;
    logic               w_clear;
    logic [STEP_W-1:0]  w_step_eff;
    logic [DUTY_W:0]    w_step_x;
    logic [DUTY_W:0]    w_up_sum;
    logic [DUTY_W-1:0]  w_floor;
    logic               w_up_arrive;
    logic               w_dn_arrive;
    logic [DUTY_W-1:0]  w_up_val;
    logic [DUTY_W-1:0]  w_dn_val;

    assign w_ramping = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);

    // Counter restarts on every reconfiguration, on disable and whenever
    // no ramp is in progress, so each new ramp starts a full interval.
    assign w_clear = cfg_valid | ~cfg_enable | ~w_ramping;

    pwm_tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (period_tick & w_ramping),
        .clear    (w_clear),
        .prescale (r_prescale),
        .step_en  (w_step_en)
    );

    // Step datapath: comparisons are done one bit wider than the duty so
    // that duty+step or floor+step can never wrap. The narrow add/subtract
    // results are only used when the comparison shows no saturation.
    assign w_step_eff  = (r_step == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : r_step;
    assign w_step_x    = {{(DUTY_W+1-STEP_W){1'b0}}, w_step_eff};
    assign w_up_sum    = {1'b0, r_duty} + w_step_x;
    assign w_up_arrive = (w_up_sum >= {1'b0, r_target});
    assign w_floor     = (r_mode == MODE_BREATHE) ? '0 : r_target;
    assign w_dn_arrive = ({1'b0, r_duty} <= ({1'b0, w_floor} + w_step_x));
    assign w_up_val    = r_duty + w_step_x[DUTY_W-1:0];
    assign w_dn_val    = r_duty - w_step_x[DUTY_W-1:0];

    // ------------------------------------------------------------------
    // FSM next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_done_ev   = 1'b0;

        if (!cfg_enable) begin
            w_state_nxt = IDLE;
        end else if (cfg_valid) begin
            // Direction is chosen from the current duty, so a mid-ramp
            // reconfiguration continues smoothly from where it is.
            if (cfg_target > r_duty) begin
                w_state_nxt = RAMP_UP;
            end else if (cfg_target < r_duty) begin
                w_state_nxt = RAMP_DOWN;
            end else begin
                w_state_nxt = HOLD;
                w_done_ev   = 1'b1;
            end
        end else if (w_step_en) begin
            case (r_state)
                RAMP_UP: begin
                    if (w_up_arrive) begin
                        w_duty_nxt = r_target;
                        if (r_mode == MODE_BREATHE) begin
                            w_state_nxt = RAMP_DOWN;
                        end else begin
                            w_state_nxt = HOLD;
                            w_done_ev   = 1'b1;
                        end
                    end else begin
                        w_duty_nxt = w_up_val;
                    end
                end
                RAMP_DOWN: begin
                    if (w_dn_arrive) begin
                        w_duty_nxt = w_floor;
                        w_done_ev  = 1'b1;
                        // A breathe with target 0 has nothing to climb to.
                        if ((r_mode == MODE_BREATHE) && (r_target != '0)) begin
                            w_state_nxt = RAMP_UP;
                        end else begin
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_duty_nxt = w_dn_val;
                    end
                end
                default: begin
                end
            endcase
        end

        // Back-to-back arrivals collapse so done stays a single-cycle pulse.
        w_done_nxt = w_done_ev & ~r_done;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty     <= '0;
            r_done     <= 1'b0;
            r_target   <= '0;
            r_step     <= '0;
            r_prescale <= '0;
            r_mode     <= MODE_RAMP;
        end else begin
            r_duty <= w_duty_nxt;
            r_done <= w_done_nxt;
            if (cfg_valid) begin
                r_target   <= cfg_target;
                r_step     <= cfg_step;
                r_prescale <= cfg_prescale;
                r_mode     <= cfg_mode;
            end
        end
    end

    assign duty_out = r_duty;
    assign busy     = w_ramping;
    assign done     = r_done;

endmodule : pwm_fade_sequencer
`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pwm_fade_sequencer
//  Description : Self-checking bench for pwm_fade_sequencer: a vector table,
//                directed corner-case sequences, and randomized traffic
//                compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_enable = 1'b0;
    logic       cfg_mode = 1'b0;
    logic [7:0] cfg_target = '0;
    logic [3:0] cfg_step = '0;
    logic [7:0] cfg_prescale = '0;
    logic       period_tick = 1'b0;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    pwm_fade_sequencer #(
        .DUTY_W  (8),
        .STEP_W  (4),
        .PRESC_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_enable   (cfg_enable),
        .cfg_mode     (cfg_mode),
        .cfg_target   (cfg_target),
        .cfg_step     (cfg_step),
        .cfg_prescale (cfg_prescale),
        .period_tick  (period_tick),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input int d, input bit b, input bit dn);
        check({name, " duty"}, {24'd0, duty_out}, d);
        check({name, " busy"}, {31'd0, busy}, {31'd0, b});
        check({name, " done"}, {31'd0, done}, {31'd0, dn});
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic cycle(input bit v, input bit t);
        cfg_valid   = v;
        period_tick = t;
        @(posedge clk);
        #1;
        cfg_valid   = 1'b0;
        period_tick = 1'b0;
    endtask

    task automatic set_cfg(input bit m, input int t, input int s, input int p);
        cfg_mode     = m;
        cfg_target   = t[7:0];
        cfg_step     = s[3:0];
        cfg_prescale = p[7:0];
    endtask

    task automatic do_reset();
        cfg_valid   = 1'b0;
        period_tick = 1'b0;
        cfg_enable  = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: duty moves by +/-step clamped at a limit; a
    // direction of 0 means "not ramping".
    // ------------------------------------------------------------------
    int m_duty, m_dir, m_cnt;
    bit m_done;
    bit l_mode;
    int l_tgt, l_stp, l_psc;

    task automatic model_reset();
        m_duty = 0; m_dir = 0; m_cnt = 0; m_done = 0;
        l_mode = 0; l_tgt = 0; l_stp = 0; l_psc = 0;
    endtask

    task automatic model_clock(input bit v, input bit en, input bit t);
        bit ev;
        int s, lim;
        ev = 0;
        if (v) begin
            l_mode = cfg_mode; l_tgt = cfg_target; l_stp = cfg_step; l_psc = cfg_prescale;
        end
        if (!en) begin
            m_dir = 0; m_cnt = 0;
        end else if (v) begin
            m_cnt = 0;
            if (l_tgt > m_duty)      m_dir = 1;
            else if (l_tgt < m_duty) m_dir = -1;
            else begin m_dir = 0; ev = 1; end
        end else if (m_dir != 0 && t) begin
            if (m_cnt < l_psc) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                s = (l_stp == 0) ? 1 : l_stp;
                if (m_dir > 0) begin
                    m_duty = (m_duty + s >= l_tgt) ? l_tgt : m_duty + s;
                    if (m_duty == l_tgt) begin
                        if (l_mode) m_dir = -1;
                        else begin m_dir = 0; ev = 1; end
                    end
                end else begin
                    lim = l_mode ? 0 : l_tgt;
                    m_duty = (m_duty - s <= lim) ? lim : m_duty - s;
                    if (m_duty == lim) begin
                        ev = 1;
                        m_dir = (l_mode && l_tgt != 0) ? 1 : 0;
                    end
                end
            end
        end
        m_done = ev && !m_done;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit    v;
        bit    en;
        bit    mode;
        int    tgt;
        int    stp;
        int    psc;
        bit    tick;
        int    exp_duty;
        bit    exp_busy;
        bit    exp_done;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit v, input int tgt, input int stp, input bit tick,
                       input int d, input bit b, input bit dn, input string name);
        vec_t r;
        r.v = v; r.en = 1'b1; r.mode = 1'b0; r.tgt = tgt; r.stp = stp; r.psc = 0;
        r.tick = tick; r.exp_duty = d; r.exp_busy = b; r.exp_done = dn; r.name = name;
        vecs.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ramp 0 -> 100 by 10, then up to 200 by 15, then down to 195.
        add(1, 100, 10, 0, 0, 1, 0, "tbl cfg100");
        for (int k = 1; k <= 10; k++)
            add(0, 100, 10, 1, 10 * k, (k != 10), (k == 10), $sformatf("tbl up%0d", k));
        add(0, 100, 10, 0, 100, 0, 0, "tbl hold idle");
        add(0, 100, 10, 1, 100, 0, 0, "tbl hold tick");
        add(1, 200, 15, 0, 100, 1, 0, "tbl cfg200");
        for (int k = 1; k <= 7; k++)
            add(0, 200, 15, 1, (k == 7) ? 200 : 100 + 15 * k, (k != 7), (k == 7),
                $sformatf("tbl up200_%0d", k));
        add(1, 195, 15, 0, 200, 1, 0, "tbl cfg195");
        add(0, 195, 15, 1, 195, 0, 1, "tbl down195");
        add(0, 195, 15, 0, 195, 0, 0, "tbl after195");
        add(1, 195, 15, 0, 195, 0, 1, "tbl cfg equal");
        add(0, 195, 15, 0, 195, 0, 0, "tbl equal after");

        // Reset state
        do_reset();
        expect_out("reset", 0, 0, 0);

        foreach (vecs[i]) begin
            cfg_enable = vecs[i].en;
            set_cfg(vecs[i].mode, vecs[i].tgt, vecs[i].stp, vecs[i].psc);
            cycle(vecs[i].v, vecs[i].tick);
            expect_out(vecs[i].name, vecs[i].exp_duty, vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Non-multiple step: 10, 20, 25
        do_reset();
        set_cfg(0, 25, 10, 0);
        cycle(1, 0);
        cycle(0, 1); expect_out("nm 10", 10, 1, 0);
        cycle(0, 1); expect_out("nm 20", 20, 1, 0);
        cycle(0, 1); expect_out("nm 25", 25, 0, 1);
        cycle(0, 1); expect_out("nm hold", 25, 0, 0);

        // Prescale 3: one step every 4th tick
        do_reset();
        set_cfg(0, 4, 1, 3);
        cycle(1, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 1);
            expect_out($sformatf("presc t%0d", i), i / 4, (i < 16), (i == 16));
            cycle(0, 0);
        end

        // Breathe 0 <-> 20 step 5: done only on return to 0
        do_reset();
        set_cfg(1, 20, 5, 0);
        cycle(1, 0);
        expect_out("br start", 0, 1, 0);
        begin
            int seq [12] = '{5, 10, 15, 20, 15, 10, 5, 0, 5, 10, 15, 20};
            for (int i = 0; i < 12; i++) begin
                cycle(0, 1);
                expect_out($sformatf("br %0d", i), seq[i], 1, (seq[i] == 0));
            end
        end

        // cfg_valid together with a tick at duty 50: the tick is discarded
        do_reset();
        set_cfg(0, 100, 10, 0);
        cycle(1, 0);
        repeat (5) cycle(0, 1);
        expect_out("co 50", 50, 1, 0);
        set_cfg(0, 30, 10, 0);
        cycle(1, 1); expect_out("co same", 50, 1, 0);
        cycle(0, 1); expect_out("co 40", 40, 1, 0);
        cycle(0, 1); expect_out("co 30", 30, 0, 1);

        // Enable drop mid-ramp, re-enable needs cfg_valid
        do_reset();
        set_cfg(0, 100, 10, 0);
        cycle(1, 0);
        repeat (3) cycle(0, 1);
        cfg_enable = 1'b0;
        cycle(0, 1); expect_out("dis 1", 30, 0, 0);
        cycle(0, 1); expect_out("dis 2", 30, 0, 0);
        cfg_enable = 1'b1;
        cycle(0, 1); expect_out("reen tick", 30, 0, 0);
        cycle(1, 0); expect_out("reen cfg", 30, 1, 0);
        cycle(0, 1); expect_out("reen 40", 40, 1, 0);

        // Asynchronous reset mid-ramp
        do_reset();
        set_cfg(0, 100, 10, 0);
        cycle(1, 0);
        repeat (2) cycle(0, 1);
        expect_out("ar pre", 20, 1, 0);
        #2 rst_n = 1'b0;
        #1 expect_out("ar async", 0, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycle(0, 1); expect_out("ar post", 0, 0, 0);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit v, t;
            if ($urandom_range(0, 149) == 0) cfg_enable = ~cfg_enable;
            v = ($urandom_range(0, 59) == 0);
            if (v) begin
                set_cfg($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255),
                        $urandom_range(0, 15), $urandom_range(0, 3));
            end
            t = ($urandom_range(0, 1) == 0);
            model_clock(v, cfg_enable, t);
            cycle(v, t);
            expect_out($sformatf("rnd %0d", n), m_duty, (m_dir != 0), m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_fade_sequencer
`default_nettype wire
